fifo_read_adapter: RTL
======================

// Module: fifo_read_adapter
// PURPOSE
//  Read-side drain for the memory_core FIFO (mode 1). Issues ren_in against FIFO empty, absorbs the
//  1-cycle read latency (ren -> data_out/valid_out) and re-presents words on a valid/ready stream.
//  Holds words in a small credit-managed buffer so downstream backpressure never loses data.
//  Also provides a drain (flush-by-reading) mode for host reconfiguration.
// PARAMETERS
//  DATA_W     16  word width; matches memory_core data_out
//  BUF_DEPTH  3   output buffer entries; >=3 required for 1 word/cycle throughput
// PORTS
//  clk          in   1          clock
//  rst_n        in   1          asynchronous reset, active-low
//  clk_en       in   1          global enable; low freezes all state, forces fifo_ren=0
//  fifo_empty   in   1          memory_core empty
//  fifo_ren     out  1          to memory_core ren_in
//  fifo_data    in   DATA_W     memory_core data_out
//  fifo_valid   in   1          memory_core valid_out (1 cycle after ren)
//  out_data     out  DATA_W     head-of-buffer word
//  out_vld      out  1          out_data valid
//  out_rdy      in   1          downstream accept
//  drain_req    in   1          level request: discard FIFO contents
//  drain_done   out  1          high while drained (FIFO empty, nothing in flight)
//  occupancy    out  $clog2(BUF_DEPTH+1)  words currently buffered
//  proto_err    out  1          sticky: fifo_valid with no read in flight
// BEHAVIOUR
//  - Reset (async, rst_n=0): fifo_ren=0, out_vld=0, out_data=0, drain_done=0, occupancy=0,
//    proto_err=0, inflight=0, state=RUN. fifo_valid ignored in first clk_en cycle after release.
//  - All updates qualified by clk_en; clk_en=0 holds every register; fifo_ren=0.
//  - fifo_ren registered-credit rule (RUN): fifo_ren = clk_en && !fifo_empty &&
//    (occupancy + inflight) < BUF_DEPTH. No combinational path out_rdy -> fifo_ren.
//  - inflight set on fifo_ren, cleared when fifo_valid seen; fifo_ren while inflight allowed.
//  - fifo_valid && inflight: push fifo_data at tail. fifo_valid && !inflight: drop word, proto_err<=1.
//  - Pop when out_vld && out_rdy; out_vld = occupancy!=0; out_data = head entry (0 when empty).
//  - Simultaneous push+pop: occupancy unchanged, order preserved; push into full buffer impossible
//    by credit rule (assertable). Pointers wrap modulo BUF_DEPTH.
//  - Latency: fifo_ren at cycle t -> out_vld earliest t+2 (fifo_valid at t+1 registered).
//  - Steady state out_rdy=1, FIFO non-empty: one word per cycle.
//  FSM (rd_state_e):
//    RUN     normal. drain_req=1 -> DRAIN (buffer cleared same edge, out_vld=0).
//    DRAIN   fifo_ren = clk_en && !fifo_empty (credits ignored); returned words discarded;
//            out_vld=0. fifo_empty && !inflight && !fifo_ren -> DRAINED.
//    DRAINED drain_done=1, fifo_ren=0, out_vld=0. drain_req=0 -> RUN. New writes stay in FIFO.
//    drain_req dropped during DRAIN -> finish drain (DRAINED) then RUN next cycle.
//  - Reset mid-operation: buffered and in-flight words lost; no output glitch beyond reset values.
// CONFIGURATION
//  `FIFO_RD_STATS_EN defined: adds ports rd_count out 32 (popped words, wraps) and
//    stall_count out 32 (cycles out_vld && !out_rdy, saturates at 32'hFFFF_FFFF); both reset 0,
//    cleared on entry to DRAIN. Undefined: ports and counters absent; core behaviour identical.
// STRUCTURE
//  fifo_rd_pkg: rd_state_e {RUN, DRAIN, DRAINED}; DEF_DATA_W=16; DEF_BUF_DEPTH=3.
//  Sub-module fifo_rd_skid_buf: BUF_DEPTH-entry circular buffer (push/pop/clear, head data,
//  count); FSM, credit logic, proto_err, stats in fifo_read_adapter.
// TESTING
//  1 Reset, FIFO holds 8'h..: words 16'h0001..16'h0004, out_rdy=1 -> out_data 1,2,3,4 on consecutive
//    cycles, first out_vld 2 cycles after first fifo_ren.
//  2 out_rdy=0 with FIFO non-empty -> exactly BUF_DEPTH(3) reads issued, occupancy=3, fifo_ren=0;
//    out_rdy=1 -> no word lost/duplicated, order kept.
//  3 fifo_valid pulsed with no prior fifo_ren -> word not buffered, proto_err=1 and stays 1.
//  4 drain_req=1 with 5 words in FIFO, 2 buffered -> out_vld=0 next cycle, 5 reads issued,
//    drain_done=1; drain_req=0 -> RUN, next written word 16'hBEEF delivered.
//  5 clk_en=0 for 4 cycles mid-stream -> fifo_ren=0, occupancy/out_data frozen; resume intact.
//  6 rst_n low while inflight=1, occupancy=2 -> all outputs reset asynchronously, no proto_err
//    after release; with `FIFO_RD_STATS_EN, rd_count/stall_count read 0.

Source files
------------

// File: rtl/fifo_rd_pkg.sv
// Shared types and defaults for the memory_core read-side adapter.
package fifo_rd_pkg;

   typedef enum logic [1:0] {
      RUN     = 2'd0,
      DRAIN   = 2'd1,
      DRAINED = 2'd2
   } rd_state_e;

   localparam int DEF_DATA_W    = 16;
   localparam int DEF_BUF_DEPTH = 3;

endpackage

// File: rtl/fifo_rd_skid_buf.sv
// Circular output buffer: push at tail, pop at head, synchronous clear, occupancy count.
module fifo_rd_skid_buf
   import fifo_rd_pkg::*;
#(
   parameter  int DATA_W = DEF_DATA_W,
   parameter  int DEPTH  = DEF_BUF_DEPTH,
   localparam int CNT_W  = $clog2(DEPTH + 1),
   localparam int PTR_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              en_i,
   input  logic              clear_i,
   input  logic              push_i,
   input  logic [DATA_W-1:0] push_data_i,
   input  logic              pop_i,
   output logic [DATA_W-1:0] head_data_o,
   output logic [CNT_W-1:0]  count_o
);

   logic [DATA_W-1:0] mem_q [DEPTH];
   logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0]  count_q, count_d;
   logic              do_push, do_pop;

   // Depth need not be a power of two, so wrap explicitly.
   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
   endfunction

   always_comb begin
      do_push  = push_i && !clear_i;
      do_pop   = pop_i && !clear_i && (count_q != '0);
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (clear_i) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (do_push) wr_ptr_d = ptr_inc(wr_ptr_q);
         if (do_pop)  rd_ptr_d = ptr_inc(rd_ptr_q);
         case ({do_push, do_pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      end else if (en_i) begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         if (do_push) mem_q[wr_ptr_q] <= push_data_i;
      end
   end

   assign head_data_o = (count_q == '0) ? '0 : mem_q[rd_ptr_q];
   assign count_o     = count_q;

endmodule

// File: rtl/fifo_read_adapter.sv
// Drains memory_core (1-cycle read latency) into a credit-managed valid/ready stream with a
// flush-by-reading drain mode. Optional FIFO_RD_STATS_EN adds rd_count/stall_count ports.
module fifo_read_adapter
   import fifo_rd_pkg::*;
#(
   parameter  int DATA_W    = DEF_DATA_W,
   parameter  int BUF_DEPTH = DEF_BUF_DEPTH,
   localparam int OCC_W     = $clog2(BUF_DEPTH + 1)
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              clk_en,
   input  logic              fifo_empty,
   output logic              fifo_ren,
   input  logic [DATA_W-1:0] fifo_data,
   input  logic              fifo_valid,
   output logic [DATA_W-1:0] out_data,
   output logic              out_vld,
   input  logic              out_rdy,
   input  logic              drain_req,
   output logic              drain_done,
   output logic [OCC_W-1:0]  occupancy,
   output logic              proto_err,
`ifdef FIFO_RD_STATS_EN
   output logic [31:0]       rd_count,
   output logic [31:0]       stall_count,
`endif
   output rd_state_e         dbg_state_o
);

   // Stream handshake: a word transfers on a clk_en rising edge where out_vld && out_rdy;
   // out_vld never depends on out_rdy, and out_data holds while out_vld && !out_rdy.

   rd_state_e        state_q, state_d;
   logic             inflight_q, inflight_d;
   logic             proto_err_q, proto_err_d;
   logic             vld_mask_q;
   logic             valid_ok, credit_ok;
   logic             buf_push, buf_pop, buf_clear;
   logic [OCC_W:0]   credit_used;

   // Credits use registered occupancy only, so out_rdy never reaches fifo_ren.
   assign credit_used = {1'b0, occupancy} + {{OCC_W{1'b0}}, inflight_q};
   assign credit_ok   = credit_used < (OCC_W + 1)'(BUF_DEPTH);
   assign out_vld     = (state_q == RUN) && (occupancy != '0);

   always_comb begin
      valid_ok  = fifo_valid && !vld_mask_q;
      state_d   = state_q;
      fifo_ren  = 1'b0;
      buf_push  = 1'b0;
      buf_pop   = 1'b0;
      buf_clear = 1'b0;
      case (state_q)
         RUN: begin
            fifo_ren = clk_en && rst_n && !fifo_empty && credit_ok;
            buf_push = valid_ok && inflight_q;
            buf_pop  = out_vld && out_rdy;
            if (drain_req) begin
               state_d   = DRAIN;
               buf_clear = 1'b1;
            end
         end
         DRAIN: begin
            // Words returned here are simply not pushed.
            fifo_ren = clk_en && rst_n && !fifo_empty;
            if (fifo_empty && !inflight_q) state_d = DRAINED;
         end
         DRAINED: begin
            if (!drain_req) state_d = RUN;
         end
         default: state_d = RUN;
      endcase
      inflight_d  = fifo_ren ? 1'b1 : (valid_ok ? 1'b0 : inflight_q);
      proto_err_d = proto_err_q || (valid_ok && !inflight_q);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= RUN;
         inflight_q  <= 1'b0;
         proto_err_q <= 1'b0;
         vld_mask_q  <= 1'b1;
      end else if (clk_en) begin
         state_q     <= state_d;
         inflight_q  <= inflight_d;
         proto_err_q <= proto_err_d;
         vld_mask_q  <= 1'b0;
      end
   end

   fifo_rd_skid_buf #(
      .DATA_W (DATA_W),
      .DEPTH  (BUF_DEPTH)
   ) u_skid_buf (
      .clk         (clk),
      .rst_n       (rst_n),
      .en_i        (clk_en),
      .clear_i     (buf_clear),
      .push_i      (buf_push),
      .push_data_i (fifo_data),
      .pop_i       (buf_pop),
      .head_data_o (out_data),
      .count_o     (occupancy)
   );

   assign drain_done  = (state_q == DRAINED);
   assign proto_err   = proto_err_q;
   assign dbg_state_o = state_q;

`ifdef FIFO_RD_STATS_EN
   logic [31:0] rd_count_q, stall_count_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_count_q    <= '0;
         stall_count_q <= '0;
      end else if (clk_en) begin
         if (state_q == RUN && drain_req) begin
            rd_count_q    <= '0;
            stall_count_q <= '0;
         end else begin
            if (buf_pop) rd_count_q <= rd_count_q + 32'd1;
            if (out_vld && !out_rdy && stall_count_q != 32'hFFFF_FFFF)
               stall_count_q <= stall_count_q + 32'd1;
         end
      end
   end

   assign rd_count    = rd_count_q;
   assign stall_count = stall_count_q;
`endif

endmodule
